vga_timing_rx: RTL and testbench
================================

// Module: vga_timing_rx
// PURPOSE
//  Receive end of the team's 640x480@60 VGA timing: samples hsync/vsync (active low, synchronous to clk_i,
//  one pixel per clock), measures line/frame timing, checks it against expected values, and recovers pixel
//  coordinates plus display-active. Used for loopback self-test of the timing generator and for
//  slaving pixel pipelines to an external sync source.
// PARAMETERS
//  H_FRAME      800  expected clocks per line (hsync fall to hsync fall)
//  V_FRAME      525  expected lines per frame (vsync fall to vsync fall, counted in hsync falls)
//  H_DISP       640  active pixels per line
//  V_DISP       480  active lines per frame
//  SYNC_X       658  x value loaded on hsync fall (makes x_o == generator xcol_o when wired back-to-back)
//  SYNC_Y       513  y value loaded on vsync fall
//  LOCK_FRAMES  2    consecutive good frames required to assert locked_o (1..15)
//  TIMEOUT      2048 clocks with no hsync fall before lock is dropped
// PORTS
//  clk_i          in   1   pixel clock (25 MHz)
//  rst_i          in   1   reset, asynchronous, active high
//  hsync_i        in   1   horizontal sync, active low
//  vsync_i        in   1   vertical sync, active low
//  xcol_o         out  11  recovered column
//  yrow_o         out  11  recovered row
//  disp_active_o  out  1   locked_o && xcol_o<H_DISP && yrow_o<V_DISP
//  locked_o       out  1   timing matches expected for LOCK_FRAMES frames
//  frame_o        out  1   one-cycle pulse on each vsync fall
//  h_period_o     out  11  last measured line length, clocks (saturate 2047)
//  h_sync_len_o   out  11  last measured hsync low width, clocks (saturate 2047)
//  v_period_o     out  11  last measured frame length, lines (saturate 2047)
//  v_sync_len_o   out  11  last measured vsync low width, lines (saturate 2047)
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; hs_prev=vs_prev=1; counters 0; good-frame count 0.
//  - Edges: hfall = hs_prev & ~hsync_i; hrise = ~hs_prev & hsync_i; vfall/vrise likewise. hs_prev/vs_prev
//    register the inputs every clock. All outputs registered: 1-cycle latency from the sampling edge.
//  - x: on hfall x<=SYNC_X; else if x==h_period_o-1 (or x==2047) x<=0; else x<=x+1.
//  - y: on vfall y<=SYNC_Y (priority over wrap); else on x wrap to 0: y<=0 if y==v_period_o-1, else y+1.
//    Before first complete measurement (period regs 0) use H_FRAME/V_FRAME as wrap limits.
//  - h_cnt: clocks since last hfall (reset to 1 on hfall, saturating). On hfall: h_period_o<=h_cnt.
//    First hfall after reset only restarts h_cnt (no h_period_o update).
//  - h_sync_len: counts clocks while hsync_i low; on hrise h_sync_len_o<=count.
//  - v_cnt counts hfalls since last vfall; on vfall v_period_o<=v_cnt, v_cnt<=0 (first vfall: restart only).
//    v_sync_len counts hfalls while vsync_i low; on vrise v_sync_len_o<=count. Simultaneous hfall+vfall:
//    hfall counted in the new frame.
//  - Lock FSM, states SEARCH -> CHECK -> LOCKED:
//    SEARCH: wait first vfall -> CHECK (good=0).
//    CHECK: on each vfall, if frame good then good+1, else good=0; good reaches LOCK_FRAMES -> LOCKED.
//    LOCKED: locked_o=1; any bad line or bad frame -> SEARCH same cycle (locked_o low next cycle).
//    Frame good: every measured h_period==H_FRAME during frame and v_period==V_FRAME.
//    Bad line: measured h_period!=H_FRAME. Timeout: h_cnt reaches TIMEOUT -> SEARCH from any state,
//    period outputs hold last values.
//  - frame_o pulses 1 cycle after the sampling edge of vfall, in all FSM states.
//  - Counters never wrap silently: saturate at 2047.
// TESTING
//  1 Reset mid-line with syncs toggling -> all outputs 0 next cycle; FSM SEARCH.
//  2 Drive team generator back-to-back (800x525, hsync 96, vsync 2 lines) -> after frame 2:
//    h_period_o=800, h_sync_len_o=96, v_period_o=525, v_sync_len_o=2, frame_o once per 420000 clocks.
//  3 Continue scenario 2 -> locked_o rises at 2nd good vfall; xcol_o/yrow_o equal generator every cycle;
//    disp_active_o equals generator disp_active.
//  4 While locked, stretch one line to 801 clocks -> locked_o low 2 cycles after that hfall sample,
//    h_period_o=801; relock after 2 further good frames.
//  5 Hold hsync_i high 2048 clocks while locked -> locked_o drops at TIMEOUT, periods unchanged.
//  6 hfall and vfall on same cycle -> y=SYNC_Y, x=SYNC_X, v_cnt=1 next cycle; frame_o pulses.

Source files
------------

// File: rtl/vga_timing_rx.sv
// ============================================================================
// Module : vga_timing_rx -- VGA sync receiver: timing measurement, lock, x/y recovery
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing_rx #(
  parameter int H_FRAME     = 800,
  parameter int V_FRAME     = 525,
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int SYNC_X      = 658,
  parameter int SYNC_Y      = 513,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 2048
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [10:0] xcol_o,
  output logic [10:0] yrow_o,
  output logic        disp_active_o,
  output logic        locked_o,
  output logic        frame_o,
  output logic [10:0] h_period_o,
  output logic [10:0] h_sync_len_o,
  output logic [10:0] v_period_o,
  output logic [10:0] v_sync_len_o
);

  localparam logic [10:0] C_MAX      = 11'd2047;
  localparam logic [11:0] C_HCNT_MAX = 12'hfff;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  good, good_nxt;
  logic        hs_prev, vs_prev, h_seen, v_seen, bad_seen;
  // One bit wider than the period outputs so the timeout count is reachable
  logic [11:0] h_cnt;
  logic [10:0] hs_cnt, v_cnt, vs_cnt;
  logic [10:0] x_nxt, y_nxt, h_lim, v_lim;
  logic        hfall, hrise, vfall, vrise, x_wrap, bad_line, frame_ok, timeout;

  assign hfall    = hs_prev & ~hsync_i;
  assign hrise    = ~hs_prev & hsync_i;
  assign vfall    = vs_prev & ~vsync_i;
  assign vrise    = ~vs_prev & vsync_i;
  assign h_lim    = (h_period_o == 11'd0) ? 11'(H_FRAME) : h_period_o;
  assign v_lim    = (v_period_o == 11'd0) ? 11'(V_FRAME) : v_period_o;
  assign x_wrap   = ~hfall & ((xcol_o == h_lim - 11'd1) | (xcol_o == C_MAX));
  assign bad_line = hfall & h_seen & (h_cnt != 12'(H_FRAME));
  assign frame_ok = ~bad_seen & ~bad_line & (v_cnt == 11'(V_FRAME));
  assign timeout  = (h_cnt >= 12'(TIMEOUT));

  always_comb begin
    x_nxt = xcol_o + 11'd1;
    if (hfall)
      x_nxt = 11'(SYNC_X);
    else if (x_wrap)
      x_nxt = 11'd0;
    y_nxt = yrow_o;
    if (vfall)
      y_nxt = 11'(SYNC_Y);
    else if (x_wrap)
      y_nxt = ((yrow_o == v_lim - 11'd1) || (yrow_o == C_MAX)) ? 11'd0 : yrow_o + 11'd1;
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    if (timeout) begin
      state_nxt = SEARCH;
      good_nxt  = 4'd0;
    end else begin
      case (state)
        SEARCH: if (vfall) begin
          state_nxt = CHECK;
          good_nxt  = 4'd0;
        end
        CHECK: if (vfall) begin
          if (frame_ok) begin
            good_nxt = good + 4'd1;
            if (good_nxt == 4'(LOCK_FRAMES))
              state_nxt = LOCKED;
          end else begin
            good_nxt = 4'd0;
          end
        end
        LOCKED: if (bad_line || (vfall && (v_cnt != 11'(V_FRAME)))) begin
          state_nxt = SEARCH;
          good_nxt  = 4'd0;
        end
        default: begin
          state_nxt = SEARCH;
          good_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= SEARCH;
      good          <= 4'd0;
      hs_prev       <= 1'b1;
      vs_prev       <= 1'b1;
      h_seen        <= 1'b0;
      v_seen        <= 1'b0;
      bad_seen      <= 1'b0;
      h_cnt         <= 12'd0;
      hs_cnt        <= 11'd0;
      v_cnt         <= 11'd0;
      vs_cnt        <= 11'd0;
      xcol_o        <= 11'd0;
      yrow_o        <= 11'd0;
      disp_active_o <= 1'b0;
      locked_o      <= 1'b0;
      frame_o       <= 1'b0;
      h_period_o    <= 11'd0;
      h_sync_len_o  <= 11'd0;
      v_period_o    <= 11'd0;
      v_sync_len_o  <= 11'd0;
    end else begin
      hs_prev       <= hsync_i;
      vs_prev       <= vsync_i;
      state         <= state_nxt;
      good          <= good_nxt;
      xcol_o        <= x_nxt;
      yrow_o        <= y_nxt;
      locked_o      <= (state == LOCKED);
      disp_active_o <= (state == LOCKED) && (x_nxt < 11'(H_DISP)) && (y_nxt < 11'(V_DISP));
      frame_o       <= vfall;

      if (hfall) begin
        h_cnt  <= 12'd1;
        h_seen <= 1'b1;
        if (h_seen)
          h_period_o <= (h_cnt > {1'b0, C_MAX}) ? C_MAX : h_cnt[10:0];
      end else if (h_cnt != C_HCNT_MAX) begin
        h_cnt <= h_cnt + 12'd1;
      end

      if (hfall)
        hs_cnt <= 11'd1;
      else if (~hsync_i && (hs_cnt != C_MAX))
        hs_cnt <= hs_cnt + 11'd1;
      if (hrise)
        h_sync_len_o <= hs_cnt;

      // An hfall coincident with vfall belongs to the new frame
      if (vfall) begin
        v_cnt  <= {10'd0, hfall};
        v_seen <= 1'b1;
        if (v_seen)
          v_period_o <= v_cnt;
      end else if (hfall && (v_cnt != C_MAX)) begin
        v_cnt <= v_cnt + 11'd1;
      end

      if (vfall)
        vs_cnt <= {10'd0, hfall};
      else if (~vsync_i && hfall && (vs_cnt != C_MAX))
        vs_cnt <= vs_cnt + 11'd1;
      if (vrise)
        v_sync_len_o <= vs_cnt;

      if (vfall)
        bad_seen <= 1'b0;
      else if (bad_line)
        bad_seen <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_rx.sv
// ============================================================================
// Module : tb_vga_timing_rx -- randomized + generator-driven bench for vga_timing_rx
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_rx;

  localparam int HF = 40, VF = 12, HD = 32, VD = 9, SX = 34, SY = 10;
  localparam int LOCKF = 2, TMO = 128, HSW = 4, FRAME_CLKS = HF * VF;
  localparam int M_SEARCH = 0, M_CHECK = 1, M_LOCKED = 2;

  logic clk = 1'b0, rst = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [10:0] xcol, yrow, hper, hsl, vper, vsl;
  logic disp, locked, frame;
  int errors = 0, checks = 0;
  bit cmp_en = 0, gen_cmp = 0, force_hi = 0, noise = 0, stretch_req = 0;
  int gx, gy, cur_len;

  vga_timing_rx #(.H_FRAME(HF), .V_FRAME(VF), .H_DISP(HD), .V_DISP(VD), .SYNC_X(SX),
                  .SYNC_Y(SY), .LOCK_FRAMES(LOCKF), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync),
    .xcol_o(xcol), .yrow_o(yrow), .disp_active_o(disp), .locked_o(locked),
    .frame_o(frame), .h_period_o(hper), .h_sync_len_o(hsl), .v_period_o(vper),
    .v_sync_len_o(vsl));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 2047) ? 2047 : v;
  endfunction

  // Reference model: event times and event counts, evaluated per sampling edge
  int  m_x, m_y, m_hper, m_hsl, m_vper, m_vsl, m_locked, m_disp, m_frame;
  int  t, t_hf, t_hl, lines, vs_lines, st, good;
  bit  hs_p, vs_p, h_seen, v_seen, bad_frame;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_p = 1; vs_p = 1; t = 0; t_hf = 0; t_hl = 0; h_seen = 0; v_seen = 0;
      lines = 0; vs_lines = 0; bad_frame = 0; st = M_SEARCH; good = 0;
      m_x = 0; m_y = 0; m_hper = 0; m_hsl = 0; m_vper = 0; m_vsl = 0;
      m_locked = 0; m_disp = 0; m_frame = 0;
    end else begin
      bit hf, hr, vf, vr, bad_line, fgood, was_locked, xwrap;
      int since_hf, hlim, vlim, nx, ny;
      hf = hs_p && !hsync; hr = !hs_p && hsync;
      vf = vs_p && !vsync; vr = !vs_p && vsync;
      since_hf = t - t_hf;
      hlim = (m_hper == 0) ? HF : m_hper;
      vlim = (m_vper == 0) ? VF : m_vper;
      bad_line = hf && h_seen && (since_hf != HF);
      fgood = !bad_frame && !bad_line && (lines == VF);
      was_locked = (st == M_LOCKED);
      if (since_hf >= TMO) begin
        st = M_SEARCH; good = 0;
      end else if (st == M_SEARCH) begin
        if (vf) begin st = M_CHECK; good = 0; end
      end else if (st == M_CHECK) begin
        if (vf) begin
          if (fgood) begin
            good++;
            if (good == LOCKF) st = M_LOCKED;
          end else good = 0;
        end
      end else if (bad_line || (vf && lines != VF)) begin
        st = M_SEARCH; good = 0;
      end
      xwrap = !hf && (m_x == hlim - 1 || m_x == 2047);
      nx = hf ? SX : (xwrap ? 0 : m_x + 1);
      ny = m_y;
      if (vf) ny = SY;
      else if (xwrap) ny = (m_y == vlim - 1 || m_y == 2047) ? 0 : m_y + 1;
      m_x = nx; m_y = ny;
      m_locked = was_locked;
      m_disp = (was_locked && nx < HD && ny < VD) ? 1 : 0;
      m_frame = vf;
      if (hr) m_hsl = sat(t - t_hl);
      if (hf) begin
        if (h_seen) m_hper = sat(since_hf);
        h_seen = 1; t_hf = t; t_hl = t;
      end
      if (vr) m_vsl = vs_lines;
      if (vf) begin
        if (v_seen) m_vper = lines;
        v_seen = 1; lines = hf; vs_lines = hf;
      end else if (hf) begin
        lines = sat(lines + 1);
        if (!vsync) vs_lines = sat(vs_lines + 1);
      end
      if (vf) bad_frame = 0;
      else if (bad_line) bad_frame = 1;
      hs_p = hsync; vs_p = vsync; t++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("xcol", xcol, m_x);       chk("yrow", yrow, m_y);
      chk("disp", disp, m_disp);    chk("locked", locked, m_locked);
      chk("frame", frame, m_frame); chk("h_period", hper, m_hper);
      chk("h_sync_len", hsl, m_hsl); chk("v_period", vper, m_vper);
      chk("v_sync_len", vsl, m_vsl);
      if (gen_cmp && locked) begin
        chk("gen_x", xcol, gx); chk("gen_y", yrow, gy);
        chk("gen_disp", disp, (gx < HD && gy < VD) ? 1 : 0);
      end
    end
  end

  // Timing generator: hsync low for HSW clocks, vsync low for 2 lines,
  // phased so the recovered x/y line up with the generator coordinates.
  task automatic gen_reset();
    gx = HF - 1; gy = VF - 1; cur_len = HF;
  endtask

  task automatic step();
    bit hs_v, vs_v;
    @(posedge clk); #1;
    if (gx >= cur_len - 1) begin
      gx = 0;
      cur_len = (stretch_req && gy == 2) ? HF + 1 : HF;
      if (cur_len != HF) stretch_req = 0;
      gy = (gy == VF - 1) ? 0 : gy + 1;
    end else gx++;
    hs_v = !(gx >= SX - 1 && gx < SX - 1 + HSW);
    vs_v = !((gy == SY - 1 && gx == HF - 1) || gy == SY || (gy == SY + 1 && gx < HF - 1));
    if (force_hi) begin hs_v = 1; vs_v = 1; end
    if (noise) begin
      if ($urandom_range(0, 149) == 0) hs_v = !hs_v;
      if ($urandom_range(0, 399) == 0) vs_v = !vs_v;
    end
    hsync = hs_v; vsync = vs_v;
  endtask

  task automatic drive(input logic h, input logic v);
    @(posedge clk); #1;
    hsync = h; vsync = v;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1; #1;
    chk("rst_x", xcol, 0);      chk("rst_y", yrow, 0);     chk("rst_disp", disp, 0);
    chk("rst_locked", locked, 0); chk("rst_frame", frame, 0); chk("rst_hper", hper, 0);
    chk("rst_hsl", hsl, 0);     chk("rst_vper", vper, 0);  chk("rst_vsl", vsl, 0);
    repeat (3) begin
      @(posedge clk); #1;
      hsync = 1'($urandom_range(0, 1)); vsync = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("rst_hold_x", xcol, 0);
    hsync = 1; vsync = 1; rst = 0;
  endtask

  initial begin
    int nfr, last_fr, cyc;
    bit found;
    #2 rst = 1;
    cmp_en = 1;
    @(negedge clk) rst = 0;

    // Random sync noise
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) != 0));

    // Reset mid-line with syncs toggling
    gen_reset();
    repeat (57) step();
    do_reset();

    // Acquire lock from a clean generator
    gen_reset(); gen_cmp = 1; nfr = 0;
    for (int i = 0; i < 4 * FRAME_CLKS && nfr < 3; i++) begin
      step(); @(negedge clk);
      if (frame) nfr++;
    end
    chk("acq_vfalls", nfr, 3);
    chk("acq_lock_pre", locked, 0);
    step(); @(negedge clk);
    chk("acq_lock_rise", locked, 1);
    chk("acq_hper", hper, HF); chk("acq_hsl", hsl, HSW);
    chk("acq_vper", vper, VF); chk("acq_vsl", vsl, 2);

    // frame_o spacing over three frames
    nfr = 0; last_fr = -1; cyc = 0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      step(); @(negedge clk);
      if (frame) begin
        if (last_fr >= 0) chk("frame_spacing", i - last_fr, FRAME_CLKS);
        last_fr = i; nfr++;
      end
    end
    chk("frame_count", nfr, 3);
    chk("lock_steady", locked, 1);

    // Stretch one line by a clock while locked
    gen_cmp = 0; stretch_req = 1; found = 0;
    for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
      step(); @(negedge clk);
      if (hper == 11'(HF + 1)) found = 1;
    end
    chk("stretch_hper", hper, HF + 1);
    chk("stretch_lock_hold", locked, 1);
    step(); @(negedge clk);
    chk("stretch_lock_drop", locked, 0);

    gen_cmp = 1; nfr = 0;
    for (int i = 0; i < 5 * FRAME_CLKS && locked == 1'b0; i++) begin
      step(); @(negedge clk);
      if (frame) nfr++;
    end
    chk("relock", locked, 1);
    chk("relock_vfalls", nfr, 3);

    // Timeout: syncs held high right after an hfall
    gen_cmp = 0;
    for (int i = 0; i < 2 * HF && gx != SX - 1; i++) step();
    chk("to_start_gx", gx, SX - 1);
    force_hi = 1;
    for (int n = 0; n <= TMO + 1; n++) begin
      step(); @(negedge clk);
      if (n == TMO) chk("to_lock_hold", locked, 1);
      if (n == TMO + 1) chk("to_lock_drop", locked, 0);
    end
    chk("to_hper", hper, HF); chk("to_vper", vper, VF);
    force_hi = 0;
    repeat (200) step();

    // hfall and vfall on the same sample
    repeat (3) drive(1, 1);
    drive(0, 0); drive(0, 0);
    @(negedge clk);
    chk("sim_x", xcol, SX); chk("sim_y", yrow, SY); chk("sim_frame", frame, 1);
    repeat (5) drive(1, 1);

    // Noisy generator with a reset in the middle
    gen_reset(); noise = 1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i == 2000) do_reset();
    end
    noise = 0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
